// File: rtl/spi_master_tx_pkg.sv
// Shared types and constants for the transmit-only SPI master.
package spi_master_tx_pkg;

  typedef enum logic [1:0] {
    StRdy   = 2'd0,
    StSckLo = 2'd1,
    StSckHi = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam int unsigned FrameBits         = 8;
  localparam int unsigned DefaultHalfCycles = 20;
  localparam int unsigned TimerWidth        = 5;

endpackage

// File: rtl/spi_half_period_timer.sv
// Half-period counter: counts up each clk, restarts on clear, flags the last cycle.
module spi_half_period_timer
  import spi_master_tx_pkg::*;
#(
  parameter int unsigned HalfCycles = DefaultHalfCycles
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  output logic [TimerWidth-1:0] count_o,
  output logic                  tc_o
);

  logic [TimerWidth-1:0] count_d, count_q;

  always_comb begin
    count_d = clr_i ? '0 : count_q + TimerWidth'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == TimerWidth'(HalfCycles - 1));

endmodule

// File: rtl/spi_master_tx.sv
// Transmit-only SPI master, mode 0, 8-bit frames sent LSB first.
module spi_master_tx
  import spi_master_tx_pkg::*;
#(
  parameter int unsigned HALF_CYCLES = DefaultHalfCycles
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       send,
  output logic       mosi,
  output logic       sck,
  output logic       ss,
  output logic       busy,
  output logic [1:0] _dbg_cs,
  output logic       _dbg_sck,
  output logic [3:0] _dbg_idx,
  output logic [4:0] _dbg_timer
);

  state_e     state_d, state_q;
  logic [7:0] buf_d, buf_q;
  logic [3:0] idx_d, idx_q;
  logic       sck_d, sck_q;
  logic       ss_d, ss_q;
  logic       mosi_d, mosi_q;
  logic       busy_d, busy_q;

  logic       tc;
  logic       timer_clr;
  logic [4:0] timer;

  // Timer is held at zero while idle and restarts on every state change.
  assign timer_clr = (state_q == StRdy) || tc;

  spi_half_period_timer #(
    .HalfCycles (HALF_CYCLES)
  ) u_timer (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (timer_clr),
    .count_o (timer),
    .tc_o    (tc)
  );

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    sck_d   = sck_q;
    ss_d    = ss_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    unique case (state_q)
      StRdy: begin
        if (send) begin
          buf_d   = data;
          ss_d    = 1'b0;
          busy_d  = 1'b1;
          mosi_d  = data[0];
          idx_d   = '0;
          state_d = StSckLo;
        end
      end
      StSckLo: begin
        if (tc) begin
          sck_d   = 1'b1;
          state_d = StSckHi;
        end
      end
      StSckHi: begin
        if (tc) begin
          sck_d = 1'b0;
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'(FrameBits - 1)) begin
            state_d = StDone;
          end else begin
            // Buffer shifts right so the next bit is always at position 1.
            buf_d   = {1'b0, buf_q[7:1]};
            mosi_d  = buf_q[1];
            state_d = StSckLo;
          end
        end
      end
      StDone: begin
        if (tc) begin
          ss_d    = 1'b1;
          busy_d  = 1'b0;
          mosi_d  = 1'b0;
          idx_d   = '0;
          state_d = StRdy;
        end
      end
      default: state_d = StRdy;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRdy;
      buf_q   <= '0;
      idx_q   <= '0;
      sck_q   <= 1'b0;
      ss_q    <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      sck_q   <= sck_d;
      ss_q    <= ss_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
    end
  end

  assign mosi       = mosi_q;
  assign sck        = sck_q;
  assign ss         = ss_q;
  assign busy       = busy_q;
  assign _dbg_cs    = state_q;
  assign _dbg_sck   = sck_q;
  assign _dbg_idx   = idx_q;
  assign _dbg_timer = timer;

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: slave-side monitor rebuilds bytes and checks them against a queue.
module tb_spi_master_tx;

  localparam int Half     = 20;
  localparam int FrameLen = 17 * Half;     // ss fall to ss rise
  localparam int BusyLen  = FrameLen + 1;  // includes the accept cycle

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       send = 1'b0;
  logic       mosi, sck, ss, busy, dbg_sck;
  logic [1:0] dbg_cs;
  logic [3:0] dbg_idx;
  logic [4:0] dbg_timer;

  int n_checks = 0;
  int n_bad    = 0;
  int frames_seen = 0;
  int nexp = 0;
  int max_timer = 0;
  int max_idx = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  spi_master_tx #(
    .HALF_CYCLES (Half)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .send       (send),
    .mosi       (mosi),
    .sck        (sck),
    .ss         (ss),
    .busy       (busy),
    ._dbg_cs    (dbg_cs),
    ._dbg_sck   (dbg_sck),
    ._dbg_idx   (dbg_idx),
    ._dbg_timer (dbg_timer)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Slave-side monitor: samples on the falling clk edge, away from DUT updates.
  initial begin
    int cyc = 0, ss_fall = 0, last_rise = 0, nbits = 0, busy_cnt = 0;
    logic prev_ss = 1'b1, prev_sck = 1'b0, prev_busy = 1'b0;
    logic [7:0] rx = 8'h00;
    logic [7:0] want;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_ss = 1'b1; prev_sck = 1'b0; prev_busy = 1'b0;
        nbits = 0; busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (dbg_cs != 2'd0) begin
          if (int'(dbg_timer) > max_timer) max_timer = int'(dbg_timer);
          if (int'(dbg_idx) > max_idx) max_idx = int'(dbg_idx);
        end
        if (prev_ss && !ss) begin
          ss_fall = cyc; nbits = 0; rx = 8'h00;
        end
        if (!prev_sck && sck) begin
          if (nbits == 0) check_eq("first_rise", cyc - ss_fall, Half);
          else            check_eq("sck_period", cyc - last_rise, 2 * Half);
          last_rise = cyc;
          if (nbits < 8) rx[nbits] = mosi;
          nbits++;
        end
        if (!prev_ss && ss) begin
          check_eq("frame_len", cyc - ss_fall, FrameLen);
          check_eq("bit_count", nbits, 8);
          check_eq("sb_nonempty", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            want = sb.pop_front();
            check_eq("rx_byte", rx, want);
          end
          frames_seen++;
        end
        if (prev_busy && !busy) begin
          check_eq("busy_len", busy_cnt + 1, BusyLen);
          busy_cnt = 0;
        end
        prev_ss = ss; prev_sck = sck; prev_busy = busy;
      end
    end
  end

  task automatic wait_frames(input int target);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (frames_seen >= target) break;
    end
    check_eq("frame_timeout", frames_seen >= target, 1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    data = b; send = 1'b1; sb.push_back(b);
    @(negedge clk);
    send = 1'b0;
    nexp++;
    wait_frames(nexp);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_ss", ss, 1);
    check_eq("rst_sck", sck, 0);
    check_eq("rst_mosi", mosi, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_cs", dbg_cs, 0);
    check_eq("rst_idx", dbg_idx, 0);
    check_eq("rst_timer", dbg_timer, 0);
    rst = 1'b0;

    // 0x55 with send held for 40 cycles; k counts negedges after raising send.
    @(negedge clk);
    data = 8'h55; send = 1'b1; sb.push_back(8'h55); nexp++;
    @(negedge clk);                                   // k=1
    check_eq("acc_cs", dbg_cs, 1);
    check_eq("acc_timer", dbg_timer, 0);
    check_eq("acc_idx", dbg_idx, 0);
    check_eq("acc_ss", ss, 0);
    check_eq("acc_busy", busy, 1);
    check_eq("acc_mosi", mosi, 1);
    repeat (19) @(negedge clk);                       // k=20
    check_eq("lo_end_cs", dbg_cs, 1);
    check_eq("lo_end_timer", dbg_timer, 19);
    @(negedge clk);                                   // k=21
    check_eq("hi_cs", dbg_cs, 2);
    check_eq("hi_timer", dbg_timer, 0);
    check_eq("hi_sck", dbg_sck, 1);
    repeat (19) @(negedge clk);                       // k=40
    send = 1'b0;
    @(negedge clk);                                   // k=41
    check_eq("bit1_cs", dbg_cs, 1);
    check_eq("bit1_idx", dbg_idx, 1);
    check_eq("bit1_mosi", mosi, 0);
    check_eq("bit1_sck", sck, 0);
    repeat (280) @(negedge clk);                      // k=321
    check_eq("done_cs", dbg_cs, 3);
    check_eq("done_idx", dbg_idx, 8);
    check_eq("done_sck", sck, 0);
    check_eq("done_ss", ss, 0);
    repeat (19) @(negedge clk);                       // k=340
    check_eq("hold_ss", ss, 0);
    check_eq("hold_busy", busy, 1);
    @(negedge clk);                                   // k=341
    check_eq("end_ss", ss, 1);
    check_eq("end_busy", busy, 0);
    check_eq("end_cs", dbg_cs, 0);
    wait_frames(nexp);

    send_byte(8'hAA);
    send_byte(8'h35);

    // Data change and send pulse mid-frame must not disturb or restart it.
    @(negedge clk);
    data = 8'h0F; send = 1'b1; sb.push_back(8'h0F); nexp++;
    @(negedge clk);
    send = 1'b0;
    repeat (100) @(negedge clk);
    data = 8'hFF; send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    wait_frames(nexp);
    repeat (50) @(negedge clk);
    check_eq("no_restart_busy", busy, 0);
    check_eq("no_restart_frames", frames_seen, nexp);

    // Send held across frame end: second frame picks up the newer data.
    @(negedge clk);
    data = 8'h81; send = 1'b1; sb.push_back(8'h81); nexp++;
    repeat (50) @(negedge clk);
    data = 8'h3C; sb.push_back(8'h3C);
    wait_frames(nexp);
    nexp++;
    @(negedge clk); #1;
    check_eq("b2b_restart", busy, 1);
    send = 1'b0;
    wait_frames(nexp);

    // Reset mid-frame aborts at once.
    @(negedge clk);
    data = 8'hC3; send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    repeat (150) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("abort_ss", ss, 1);
    check_eq("abort_sck", sck, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_mosi", mosi, 0);
    check_eq("abort_cs", dbg_cs, 0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    send_byte(8'h5A);

    repeat (5) @(negedge clk);
    check_eq("sb_drained", sb.size(), 0);
    check_eq("max_timer", max_timer, Half - 1);
    check_eq("max_idx", max_idx, 8);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
